alu_cmd_queue: RTL and testbench

ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_cmd_queue.sv | 158 +++++++++++++++
 tb/tb_alu_cmd_queue.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, the packed command record and
// an opcode legality helper used by the command queue.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;

    // Width of the occupancy counter shared by the queue and its users.
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } alu_cmd_t;

    // Opcodes 110 and 111 have no ALU operation behind them.
    function automatic logic op_is_illegal(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: show-ahead FIFO of ALU commands with sticky error flags.
// Full queues refuse pushes (no bypass), illegal opcodes are consumed but
// not stored. Optional macro ALU_CMDQ_DIVZ_FILTER_EN also consumes and drops
// divide-by-zero commands and reports them on err_divz; without it err_divz
// is tied low and such commands are queued like any other.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_a,
    output logic [3:0]       out_b,
    output logic [2:0]       out_op,
    output logic [CNT_W-1:0] count,
    output logic             err_ovf,
    output logic             err_ill,
    output logic             err_divz,
    input  logic             clr_err
);

    localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    alu_cmd_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             err_ovf_reg, err_ill_reg;

    alu_cmd_t cmd_in;
    alu_cmd_t head;
    logic     accept;
    logic     ill_hit;
    logic     divz_hit;
    logic     push;
    logic     pop;
    logic     drop;

    assign cmd_in = '{a: in_a, b: in_b, op: in_op};

    // Handshake: readiness depends only on occupancy, so a full queue stays
    // closed even when the head is being consumed in the same cycle.
    assign in_ready  = (count_reg < DEPTH_CNT);
    assign out_valid = (count_reg != '0);
    assign accept    = in_valid & in_ready;
    assign drop      = in_valid & ~in_ready;
    assign ill_hit   = accept & op_is_illegal(in_op);

`ifdef ALU_CMDQ_DIVZ_FILTER_EN
    assign divz_hit  = accept & (in_op == OP_DIV) & (in_b == 4'd0);
`else
    assign divz_hit  = 1'b0;
`endif

    // Consumed-but-filtered commands complete the handshake without storage.
    assign push = accept & ~ill_hit & ~divz_hit;
    assign pop  = out_valid & out_ready;

    // Next-state for pointers and occupancy; pointers wrap naturally since
    // DEPTH is a power of two.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // State register: reset discards every entry and any same-cycle traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Sticky error flags; a set event in the clearing cycle keeps the flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf_reg <= 1'b0;
            err_ill_reg <= 1'b0;
        end else begin
            err_ovf_reg <= drop | (err_ovf_reg & ~clr_err);
            err_ill_reg <= ill_hit | (err_ill_reg & ~clr_err);
        end
    end

`ifdef ALU_CMDQ_DIVZ_FILTER_EN
    logic err_divz_reg;

    // Sticky divide-by-zero flag, same set-wins rule as the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_divz_reg <= 1'b0;
        end else begin
            err_divz_reg <= divz_hit | (err_divz_reg & ~clr_err);
        end
    end

    assign err_divz = err_divz_reg;
`else
    assign err_divz = 1'b0;
`endif

    // Storage entries: each slot captures the command when the write pointer
    // selects it. Contents are not reset; occupancy alone defines validity.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst_n && push && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem[gi] <= cmd_in;
                end
            end
        end
    endgenerate

    // Show-ahead head: present the oldest entry, force zeros when empty.
    always_comb begin
        head   = mem[rd_ptr_reg];
        out_a  = 4'd0;
        out_b  = 4'd0;
        out_op = 3'd0;
        if (out_valid) begin
            out_a  = head.a;
            out_b  = head.b;
            out_op = head.op;
        end
    end

    assign count   = count_reg;
    assign err_ovf = err_ovf_reg;
    assign err_ill = err_ill_reg;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Testbench for alu_cmd_queue: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// queue-based behavioural model. Honours ALU_CMDQ_DIVZ_FILTER_EN.
module tb_alu_cmd_queue;
    import alu_pkg::*;

    localparam int DEPTH = 4;
`ifdef ALU_CMDQ_DIVZ_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_a;
    logic [3:0] out_b;
    logic [2:0] out_op;
    logic [3:0] count;
    logic       err_ovf;
    logic       err_ill;
    logic       err_divz;
    logic       clr_err;

    int tests = 0;
    int fails = 0;

    // Behavioural model state.
    alu_cmd_t mq[$];
    bit       m_ovf;
    bit       m_ill;
    bit       m_divz;

    always #5 clk = ~clk;

    alu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_op    (in_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_op   (out_op),
        .count    (count),
        .err_ovf  (err_ovf),
        .err_ill  (err_ill),
        .err_divz (err_divz),
        .clr_err  (clr_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply the rules to the inputs that were present at the edge just taken.
    task automatic model_edge();
        bit       full;
        bit       take;
        bit       ill;
        bit       dz;
        alu_cmd_t c;
        if (!rst_n) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_ill  = 1'b0;
            m_divz = 1'b0;
            $display("[TB] t=%0t reset", $time);
            return;
        end
        full = (mq.size() >= DEPTH);
        take = in_valid && !full;
        ill  = take && (in_op >= 3'd6);
        dz   = take && FILTER && (in_op == OP_DIV) && (in_b == 4'd0);
        if (mq.size() != 0 && out_ready) begin
            c = mq.pop_front();
            $display("[TB] t=%0t pop  a=%0d b=%0d op=%0d", $time, c.a, c.b, c.op);
        end
        if (take && !ill && !dz) begin
            c.a  = in_a;
            c.b  = in_b;
            c.op = in_op;
            mq.push_back(c);
            $display("[TB] t=%0t push a=%0d b=%0d op=%0d size=%0d", $time, c.a, c.b, c.op, mq.size());
        end else if (in_valid) begin
            $display("[TB] t=%0t drop a=%0d b=%0d op=%0d full=%0d", $time, in_a, in_b, in_op, full);
        end
        m_ovf  = (in_valid && full) || (m_ovf && !clr_err);
        m_ill  = ill || (m_ill && !clr_err);
        m_divz = dz || (m_divz && !clr_err);
    endtask

    task automatic compare();
        int ea;
        int eb;
        int eo;
        ea = 0;
        eb = 0;
        eo = 0;
        if (mq.size() != 0) begin
            ea = mq[0].a;
            eb = mq[0].b;
            eo = mq[0].op;
        end
        chk("count",     count,     mq.size());
        chk("in_ready",  in_ready,  (mq.size() < DEPTH) ? 1 : 0);
        chk("out_valid", out_valid, (mq.size() != 0) ? 1 : 0);
        chk("out_a",     out_a,     ea);
        chk("out_b",     out_b,     eb);
        chk("out_op",    out_op,    eo);
        chk("err_ovf",   err_ovf,   m_ovf);
        chk("err_ill",   err_ill,   m_ill);
        chk("err_divz",  err_divz,  m_divz);
    endtask

    // One clock: edge, model update, then sample outputs just after the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive(input bit v, input int a, input int b, input int op,
                         input bit ordy, input bit clr);
        in_valid  = v;
        in_a      = 4'(a);
        in_b      = 4'(b);
        in_op     = 3'(op);
        out_ready = ordy;
        clr_err   = clr;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
        chk("reset count",     count,     0);
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready",  in_ready,  1);

        // Single push into an empty queue.
        drive(1'b1, 7, 3, OP_ADD, 1'b0, 1'b0);
        step();
        idle();
        chk("single out_valid", out_valid, 1);
        chk("single out_a",     out_a,     7);
        chk("single out_b",     out_b,     3);
        chk("single out_op",    out_op,    0);
        chk("single count",     count,     1);

        // Overflow: five pushes into a depth-4 queue, then drain.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, i, i, i % 6, 1'b0, 1'b0);
            step();
            if (i == 4) chk("full in_ready", in_ready, 0);
        end
        idle();
        chk("ovf flag",  err_ovf, 1);
        chk("ovf count", count,   4);
        for (int i = 1; i <= 4; i++) begin
            chk("drain order", out_a, i);
            drive(1'b0, 0, 0, 0, 1'b1, 1'b0);
            step();
        end
        idle();
        chk("drained count", count, 0);

        // Simultaneous push and pop at count=2.
        do_reset();
        drive(1'b1, 10, 1, OP_SUB, 1'b0, 1'b0);
        step();
        drive(1'b1, 11, 2, OP_MUL, 1'b0, 1'b0);
        step();
        chk("pp head before", out_a, 10);
        drive(1'b1, 12, 3, OP_OR, 1'b1, 1'b0);
        step();
        idle();
        chk("pp count",      count, 2);
        chk("pp head after", out_a, 11);

        // Illegal opcode, clear, and set-wins-over-clear.
        drive(1'b1, 1, 1, 6, 1'b0, 1'b0);
        step();
        idle();
        chk("ill count", count,   2);
        chk("ill flag",  err_ill, 1);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1);
        step();
        idle();
        chk("ill cleared", err_ill, 0);
        drive(1'b1, 2, 2, 7, 1'b0, 1'b1);
        step();
        idle();
        chk("set wins", err_ill, 1);

        // Divide by zero: filtered or queued depending on the build.
        do_reset();
        drive(1'b1, 9, 0, OP_DIV, 1'b0, 1'b0);
        step();
        idle();
        chk("divz count", count,    FILTER ? 0 : 1);
        chk("divz flag",  err_divz, FILTER ? 1 : 0);

        // Reset during traffic.
        do_reset();
        drive(1'b1, 1, 1, 7, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3 + i, 1, OP_AND, 1'b0, 1'b0);
            step();
        end
        chk("pre-reset count", count, 3);
        drive(1'b1, 15, 15, OP_ADD, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        chk("rst count",     count,     0);
        chk("rst out_valid", out_valid, 0);
        chk("rst flags",     {err_ovf, err_ill, err_divz}, 0);
        drive(1'b1, 6, 6, OP_OR, 1'b0, 1'b0);
        step();
        idle();
        chk("post-rst head", out_a, 6);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 15),
                  ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15),
                  $urandom_range(0, 7),
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0);
            step();
        end
        rst_n = 1'b1;
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
